// File: rtl/bank_cmd_arbiter_pkg.sv
// types_def: shared encodings for the bank command arbiter.
package types_def;
    localparam int read_entries_log = 6;
    typedef enum logic {REQ_READ = 1'b0, REQ_WRITE = 1'b1} req_type_e;
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_MODE  = 2'd1,
        WRITE_MODE = 2'd2,
        TURNAROUND = 2'd3
    } arb_state_e;
endpackage

// File: rtl/bank_cmd_arbiter_rr_picker.sv
// rr_picker: one-hot round-robin pick, searching from ptr+1 upward with wrap.
module rr_picker #(
    parameter int N  = 16,
    parameter int BW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [BW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [BW-1:0] idx,
    output logic          any
);
    logic [BW-1:0] k;
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int i = 1; i <= N; i++) begin
            k = BW'((int'(ptr) + i) % N);
            if (!any && req[k]) begin
                any = 1'b1;
                idx = k;
            end
        end
        if (any) gnt[idx] = 1'b1;
    end
endmodule

// File: rtl/bank_cmd_arbiter.sv
// bank_cmd_arbiter: picks one bank command per cycle, batching reads and writes
// into bursts with a fixed idle gap on every direction change.
module bank_cmd_arbiter import types_def::*; #(
    parameter int NUM_BANKS   = 16,
    parameter int ROW_W       = 16,
    parameter int BURST_MAX   = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_BANKS-1:0]                  bank_valid,
    input  logic [NUM_BANKS-1:0]                  bank_type,
    input  logic [NUM_BANKS*read_entries_log-1:0] bank_index,
    input  logic [NUM_BANKS*ROW_W-1:0]            bank_row,
    output logic [NUM_BANKS-1:0]                  bank_grant,
    output logic                                  cmd_valid,
    input  logic                                  cmd_ready,
    output logic [3:0]                            cmd_bank,
    output logic                                  cmd_type,
    output logic [read_entries_log-1:0]           cmd_index,
    output logic [ROW_W-1:0]                      cmd_row,
    output logic [1:0]                            arb_state
);
    localparam int BW = $clog2(NUM_BANKS);
    localparam int CW = $clog2(BURST_MAX + 1);
    localparam int TW = $clog2(TURN_CYCLES + 1);
    arb_state_e           state;
    logic                 to_write;
    logic [BW-1:0]        last_granted;
    logic [CW-1:0]        burst_cnt;
    logic [TW-1:0]        turn_cnt;
    logic [NUM_BANKS-1:0] rd_req, wr_req, same_req, opp_req, pick_gnt;
    logic [BW-1:0]        pick_idx;
    logic                 pick_any, in_mode, is_write, load_ok, switch_now, grant_en;
    assign rd_req     = bank_valid & ~bank_type;
    assign wr_req     = bank_valid & bank_type;
    assign in_mode    = state == READ_MODE || state == WRITE_MODE;
    assign is_write   = state == WRITE_MODE;
    assign same_req   = is_write ? wr_req : rd_req;
    assign opp_req    = is_write ? rd_req : wr_req;
    assign load_ok    = !cmd_valid || cmd_ready;
    // Burst limit only matters when the other direction is actually waiting.
    assign switch_now = in_mode && |opp_req && (!(|same_req) || burst_cnt == CW'(BURST_MAX));
    assign grant_en   = in_mode && !switch_now && load_ok && pick_any;
    assign bank_grant = grant_en ? pick_gnt : '0;
    assign arb_state  = state;
    rr_picker #(.N(NUM_BANKS), .BW(BW)) u_picker (
        .req (same_req),
        .ptr (last_granted),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            to_write     <= 1'b0;
            last_granted <= BW'(NUM_BANKS - 1);
            burst_cnt    <= '0;
            turn_cnt     <= '0;
            cmd_valid    <= 1'b0;
            cmd_bank     <= '0;
            cmd_type     <= 1'b0;
            cmd_index    <= '0;
            cmd_row      <= '0;
        end else begin
            if (load_ok) cmd_valid <= grant_en;
            if (grant_en) begin
                cmd_bank     <= 4'(pick_idx);
                cmd_type     <= bank_type[pick_idx];
                cmd_index    <= bank_index[pick_idx*read_entries_log +: read_entries_log];
                cmd_row      <= bank_row[pick_idx*ROW_W +: ROW_W];
                last_granted <= pick_idx;
                burst_cnt    <= burst_cnt == CW'(BURST_MAX) ? burst_cnt : burst_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (|rd_req) begin
                        state     <= READ_MODE;
                        burst_cnt <= '0;
                    end else if (|wr_req) begin
                        state     <= WRITE_MODE;
                        burst_cnt <= '0;
                    end
                end
                READ_MODE, WRITE_MODE: begin
                    if (switch_now) begin
                        state    <= TURNAROUND;
                        turn_cnt <= '0;
                        to_write <= !is_write;
                    end
                end
                default: begin
                    turn_cnt <= turn_cnt + 1'b1;
                    if (turn_cnt == TW'(TURN_CYCLES - 1)) begin
                        state     <= to_write ? WRITE_MODE : READ_MODE;
                        burst_cnt <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// tb_bank_cmd_arbiter: per-bank command queues drive the arbiter; a behavioural
// model of the arbitration rules predicts every grant and command.
module tb_bank_cmd_arbiter;
    import types_def::*;
    localparam int NB = 16, RW = 16, IW = read_entries_log, BM = 8, TC = 2, QD = 16;
    logic              clk = 1'b0;
    logic              rst_n;
    logic [NB-1:0]     bank_valid, bank_type, bank_grant;
    logic [NB*IW-1:0]  bank_index;
    logic [NB*RW-1:0]  bank_row;
    logic              cmd_valid, cmd_ready, cmd_type;
    logic [3:0]        cmd_bank;
    logic [IW-1:0]     cmd_index;
    logic [RW-1:0]     cmd_row;
    logic [1:0]        arb_state;
    always #5 clk = ~clk;
    bank_cmd_arbiter #(.NUM_BANKS(NB), .ROW_W(RW), .BURST_MAX(BM), .TURN_CYCLES(TC)) dut (
        .clk(clk), .rst_n(rst_n), .bank_valid(bank_valid), .bank_type(bank_type),
        .bank_index(bank_index), .bank_row(bank_row), .bank_grant(bank_grant),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_bank(cmd_bank),
        .cmd_type(cmd_type), .cmd_index(cmd_index), .cmd_row(cmd_row), .arb_state(arb_state)
    );
    typedef struct packed {logic t; logic [IW-1:0] idx; logic [RW-1:0] row;} cmd_t;
    cmd_t          qd [NB][QD];
    int            qn [NB];
    logic [NB-1:0] mask;
    int            ready_mode;
    int            checks = 0, errors = 0, cyc, turn_seen;
    int            log_bank[$], log_cyc[$];
    logic [4+IW+RW:0] obs_cmd;
    arb_state_e    m_state;
    int            m_last, m_burst, m_left, m_bank;
    bit            m_to_wr, m_cv;
    cmd_t          m_cmd;
    task automatic push(input int b, input logic t);
        if (qn[b] < QD) begin
            qd[b][qn[b]] = {t, IW'($urandom), RW'($urandom)};
            qn[b]++;
        end
    endtask
    task automatic pop(input int b);
        for (int i = 0; i < QD - 1; i++) qd[b][i] = qd[b][i+1];
        qn[b]--;
    endtask
    task automatic model_reset();
        m_state = IDLE; m_last = NB - 1; m_burst = 0; m_left = 0; m_bank = 0;
        m_to_wr = 0; m_cv = 0; m_cmd = '0; mask = '0; cyc = 0; turn_seen = 0;
        for (int b = 0; b < NB; b++) begin
            qn[b] = 0;
            for (int i = 0; i < QD; i++) qd[b][i] = '0;
        end
        log_bank.delete(); log_cyc.delete();
    endtask
    task automatic drive_idle();
        bank_valid = '0; bank_type = '0; bank_index = '0; bank_row = '0; cmd_ready = 1'b0;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic step();
        logic [NB-1:0] v, eg;
        bit rd, wr, same, opp, sw, lok, wmode, inmode;
        int g;
        @(negedge clk);
        cmd_ready = ready_mode == 1 ? 1'b1 : ready_mode == 2 ? 1'b0 : ($urandom_range(0, 3) != 0);
        for (int b = 0; b < NB; b++) begin
            v[b] = qn[b] > 0 && !mask[b];
            bank_valid[b] = v[b];
            bank_type[b] = qn[b] > 0 ? qd[b][0].t : 1'b0;
            bank_index[b*IW +: IW] = qd[b][0].idx;
            bank_row[b*RW +: RW] = qd[b][0].row;
        end
        #1;
        inmode = m_state == READ_MODE || m_state == WRITE_MODE;
        wmode = m_state == WRITE_MODE;
        rd = 0; wr = 0;
        for (int b = 0; b < NB; b++) if (v[b]) begin
            if (qd[b][0].t) wr = 1; else rd = 1;
        end
        same = wmode ? wr : rd;
        opp = wmode ? rd : wr;
        sw = inmode && opp && (!same || m_burst == BM);
        lok = !m_cv || cmd_ready;
        g = -1;
        if (inmode && !sw && lok)
            for (int o = 1; o <= NB; o++) begin
                int b = (m_last + o) % NB;
                if (g < 0 && v[b] && qd[b][0].t == wmode) g = b;
            end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        obs_cmd = {cmd_bank, cmd_type, cmd_index, cmd_row};
        if (arb_state === TURNAROUND) turn_seen++;
        checks++;
        if (bank_grant !== eg) begin
            errors++; $display("FAIL grant cyc %0d: got %h expected %h", cyc, bank_grant, eg);
        end
        checks++;
        if (arb_state !== m_state) begin
            errors++; $display("FAIL arb_state cyc %0d: got %0d expected %0d", cyc, arb_state, m_state);
        end
        checks++;
        if (cmd_valid !== m_cv) begin
            errors++; $display("FAIL cmd_valid cyc %0d: got %b expected %b", cyc, cmd_valid, m_cv);
        end
        if (m_cv) begin
            checks++;
            if (obs_cmd !== {4'(m_bank), m_cmd}) begin
                errors++; $display("FAIL cmd fields cyc %0d: got %h expected %h", cyc, obs_cmd, {4'(m_bank), m_cmd});
            end
        end
        if (g >= 0) begin log_bank.push_back(g); log_cyc.push_back(cyc); end
        @(posedge clk);
        if (g >= 0) begin
            m_cv = 1; m_cmd = qd[g][0]; m_bank = g; m_last = g;
            if (m_burst < BM) m_burst++;
            pop(g);
        end else if (lok) m_cv = 0;
        case (m_state)
            IDLE: if (rd) begin m_state = READ_MODE; m_burst = 0; end
                  else if (wr) begin m_state = WRITE_MODE; m_burst = 0; end
            READ_MODE, WRITE_MODE: if (sw) begin m_state = TURNAROUND; m_left = TC; m_to_wr = !wmode; end
            default: begin
                m_left--;
                if (m_left == 0) begin m_state = m_to_wr ? WRITE_MODE : READ_MODE; m_burst = 0; end
            end
        endcase
        cyc++;
    endtask
    task automatic check_log(input string name, input int exp_b[$]);
        checks++;
        if (log_bank.size() != exp_b.size()) begin
            errors++; $display("FAIL %s grant count: got %0d expected %0d", name, log_bank.size(), exp_b.size());
        end else
            for (int i = 0; i < exp_b.size(); i++) begin
                checks++;
                if (log_bank[i] != exp_b[i]) begin
                    errors++; $display("FAIL %s grant %0d: got bank %0d expected %0d", name, i, log_bank[i], exp_b[i]);
                end
            end
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        bank_valid = '1; bank_type = 16'h00ff; bank_index = '1; bank_row = '1; cmd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (bank_grant !== '0 || cmd_valid !== 1'b0 || arb_state !== IDLE) begin
            errors++; $display("FAIL reset ctrl: got grant=%h valid=%b state=%0d expected 0/0/IDLE", bank_grant, cmd_valid, arb_state);
        end
        checks++;
        if ({cmd_bank, cmd_type, cmd_index, cmd_row} !== '0) begin
            errors++; $display("FAIL reset fields: got %h expected 0", {cmd_bank, cmd_type, cmd_index, cmd_row});
        end
    endtask
    task automatic test_round_robin();
        do_reset(); ready_mode = 1;
        push(3, REQ_READ); push(7, REQ_READ); push(12, REQ_READ);
        repeat (6) step();
        check_log("round_robin", '{3, 7, 12});
        checks++;
        if (log_cyc.size() != 3 || log_cyc[2] - log_cyc[0] != 2) begin
            errors++; $display("FAIL round_robin spacing: got %0d grants not back-to-back, expected 3 consecutive", log_cyc.size());
        end
    endtask
    task automatic test_wrap();
        do_reset(); ready_mode = 1;
        push(15, REQ_READ);
        repeat (4) step();
        push(0, REQ_READ); push(15, REQ_READ);
        repeat (5) step();
        check_log("wrap", '{15, 0, 15});
    endtask
    task automatic test_burst_switch();
        do_reset(); ready_mode = 1;
        repeat (10) push(2, REQ_READ);
        push(5, REQ_WRITE);
        repeat (30) step();
        check_log("burst_switch", '{2, 2, 2, 2, 2, 2, 2, 2, 5, 2, 2});
        checks++;
        if (turn_seen != 2 * TC) begin
            errors++; $display("FAIL burst_switch turnaround cycles: got %0d expected %0d", turn_seen, 2 * TC);
        end
    endtask
    task automatic test_stall();
        logic [4+IW+RW:0] snap;
        int ng;
        do_reset(); ready_mode = 1;
        repeat (4) push(1, REQ_READ);
        repeat (3) step();
        ready_mode = 2; ng = log_bank.size();
        step();
        snap = obs_cmd;
        checks++;
        if (snap[4+IW+RW -: 4] !== 4'd1) begin
            errors++; $display("FAIL stall held bank: got %0d expected 1", snap[4+IW+RW -: 4]);
        end
        repeat (4) begin
            step();
            checks++;
            if (obs_cmd !== snap) begin
                errors++; $display("FAIL stall stability: got %h expected %h", obs_cmd, snap);
            end
        end
        checks++;
        if (log_bank.size() != ng) begin
            errors++; $display("FAIL stall grants: got %0d expected 0", log_bank.size() - ng);
        end
        ready_mode = 1;
        step();
        checks++;
        if (log_bank.size() != ng + 1) begin
            errors++; $display("FAIL stall release grants: got %0d expected 1", log_bank.size() - ng);
        end
    endtask
    task automatic test_mixed_from_reset();
        do_reset(); ready_mode = 1;
        push(4, REQ_WRITE); push(9, REQ_READ); push(10, REQ_WRITE); push(1, REQ_READ);
        repeat (3) step();
        checks++;
        if (log_cyc.size() < 1 || log_cyc[0] != 1 || log_bank[0] != 1 || turn_seen != 0) begin
            errors++; $display("FAIL mixed_from_reset: got %0d grants, turnaround %0d expected first read bank 1 at cycle 1", log_cyc.size(), turn_seen);
        end
    endtask
    task automatic test_async_reset();
        do_reset(); ready_mode = 1;
        repeat (4) push(6, REQ_READ);
        repeat (3) step();
        ready_mode = 2;
        repeat (2) step();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || arb_state !== IDLE || bank_grant !== '0) begin
            errors++; $display("FAIL async_reset: got valid=%b state=%0d grant=%h expected 0/IDLE/0", cmd_valid, arb_state, bank_grant);
        end
        drive_idle();
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 1;
        push(8, REQ_WRITE); push(3, REQ_WRITE);
        repeat (4) step();
        check_log("after_reset", '{3, 8});
        checks++;
        if (log_cyc.size() < 1 || log_cyc[0] < 1) begin
            errors++; $display("FAIL after_reset first grant: got %0d grants, expected first at cycle >= 1", log_cyc.size());
        end
    endtask
    task automatic test_random();
        do_reset(); ready_mode = 0;
        repeat (800) begin
            if ($urandom_range(0, 2) == 0) push($urandom_range(0, NB - 1), 1'($urandom));
            if ($urandom_range(0, 3) == 0) push($urandom_range(0, NB - 1), 1'($urandom));
            mask = NB'($urandom & $urandom & $urandom);
            step();
        end
        checks++;
        if (log_bank.size() < 100) begin
            errors++; $display("FAIL random progress: got %0d grants expected at least 100", log_bank.size());
        end
    endtask
    initial begin
        ready_mode = 1;
        model_reset();
        test_reset();
        test_round_robin();
        test_wrap();
        test_burst_switch();
        test_stall();
        test_mixed_from_reset();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
